// File: rtl/adc_spi_reader_pkg.sv
// Shared definitions for the ADC serial link: receive FSM states and default frame geometry.
// The sample-processing block reuses the frame constants.
package adc_spi_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SHIFT,
    DONE,
    GAP
  } adc_state_t;

  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_DATA_BITS  = 12;

endpackage

// File: rtl/adc_spi_reader_sclk_edge_detect.sv
// Single-cycle rise/fall strobes for the divided serial clock.
// sclk_in is already synchronous to clknexys, so one register is enough.
module sclk_edge_detect (
  input  logic clknexys,
  input  logic rst,
  input  logic sclk_in,
  output logic rise,
  output logic fall
);

  logic sclk_d;

  always_ff @(posedge clknexys or negedge rst) begin
    if (!rst) begin
      sclk_d <= 1'b0;
    end else begin
      sclk_d <= sclk_in;
    end
  end

  assign rise = sclk_in & ~sclk_d;
  assign fall = ~sclk_in & sclk_d;

endmodule

// File: rtl/adc_spi_reader.sv
// Serial receive engine for the ADC: gates SCLK with chip select, shifts in one frame
// per conversion and presents the low DATA_BITS as a sample with a one-cycle strobe.
module adc_spi_reader
  import adc_spi_reader_pkg::*;
#(
  parameter int FRAME_BITS = ADC_FRAME_BITS,
  parameter int DATA_BITS  = ADC_DATA_BITS,
  parameter int GAP_TICKS  = 2
) (
  input  logic                 clknexys,
  input  logic                 rst,
  input  logic                 sclk_in,
  input  logic                 start,
  input  logic                 sdata,
  output logic                 cs_n,
  output logic                 sclk_out,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  output logic                 busy
);

  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam int GAP_W = $clog2(GAP_TICKS + 1);

  adc_state_t             state;
  adc_state_t             state_next;
  logic                   rise;
  logic                   fall;
  logic [BIT_W-1:0]       bit_cnt;
  logic [GAP_W-1:0]       gap_cnt;
  logic [FRAME_BITS-1:0]  shreg;
  logic [FRAME_BITS-1:0]  shreg_next;
  logic                   last_bit;
  logic                   gap_end;

  sclk_edge_detect u_edge (
    .clknexys (clknexys),
    .rst      (rst),
    .sclk_in  (sclk_in),
    .rise     (rise),
    .fall     (fall)
  );

  // Leading bits of the frame simply fall off the top of the shift register.
  assign shreg_next = FRAME_BITS'({shreg, sdata});
  assign last_bit   = rise && (bit_cnt == BIT_W'(FRAME_BITS - 1));
  assign gap_end    = fall && (gap_cnt == GAP_W'(GAP_TICKS - 1));
  assign sclk_out   = sclk_in | cs_n;

  always_ff @(posedge clknexys or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start)    state_next = ARM;
      ARM:     if (fall)     state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:                  state_next = GAP;
      GAP:     if (gap_end)  state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // Sample and cs_n are loaded on the last rise so both change in the strobe cycle,
  // which keeps cs_n high before the following SCLK fall even at divide-by-2.
  always_ff @(posedge clknexys or negedge rst) begin
    if (!rst) begin
      cs_n    <= 1'b1;
      bit_cnt <= '0;
      gap_cnt <= '0;
      shreg   <= '0;
      sample  <= '0;
    end else begin
      unique case (state)
        ARM: begin
          if (fall) begin
            cs_n    <= 1'b0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (rise) begin
            shreg <= shreg_next;
            if (last_bit) begin
              sample <= shreg_next[DATA_BITS-1:0];
              cs_n   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        DONE: begin
          gap_cnt <= '0;
        end
        GAP: begin
          if (fall) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    sample_valid = (state == DONE);
    busy         = (state != IDLE);
  end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Scoreboard bench for adc_spi_reader: an ADC model serves queued frames and pushes the
// hand-computed sample; a monitor pops and compares on every sample_valid.
module tb_adc_spi_reader;

  logic        clknexys = 1'b0;
  logic        rst      = 1'b0;
  logic        sclk_in  = 1'b0;
  logic        start    = 1'b0;
  logic        sdata    = 1'b0;
  logic        cs_n;
  logic        sclk_out;
  logic [11:0] sample;
  logic        sample_valid;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] frame_q[$];
  logic [11:0] expv_q[$];
  logic [11:0] exp_q[$];

  int          half_period = 0;
  int          sclk_cnt    = 0;
  bit          rand_sclk   = 1'b1;
  bit          serving     = 1'b0;
  bit          last_sclk   = 1'b0;
  bit          rise_seen;
  logic [15:0] cur_frame   = '0;
  int          rise_idx    = 0;
  int          served      = 0;
  int          valid_count = 0;

  bit   check_edges = 1'b0;
  bit   check_gap   = 1'b0;
  bit   had_frame   = 1'b0;
  int   so_edges    = 0;
  int   gap_falls   = 0;
  logic cs_prev     = 1'b1;
  logic so_prev     = 1'b1;
  logic s_prev      = 1'b0;

  adc_spi_reader dut (
    .clknexys     (clknexys),
    .rst          (rst),
    .sclk_in      (sclk_in),
    .start        (start),
    .sdata        (sdata),
    .cs_n         (cs_n),
    .sclk_out     (sclk_out),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  always #5 clknexys = ~clknexys;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  task automatic pushFrame(input logic [15:0] frame, input logic [11:0] expected);
    frame_q.push_back(frame);
    expv_q.push_back(expected);
  endtask

  // SCLK generator and ADC model: next MSB-first bit is presented after each sampled rise.
  always @(posedge clknexys) begin
    if (!rst) begin
      rise_seen = 1'b0;
      last_sclk = 1'b0;
    end else begin
      rise_seen = sclk_in & ~last_sclk & ~cs_n;
      last_sclk = sclk_in;
    end
    #1;
    if (!rst) serving = 1'b0;
    if (rise_seen && serving) rise_idx++;
    if (serving && cs_n) serving = 1'b0;
    if (!serving && !cs_n && rst) begin
      served++;
      if (frame_q.size() > 0) begin
        cur_frame = frame_q.pop_front();
        exp_q.push_back(expv_q.pop_front());
      end else begin
        cur_frame = '0;
        checkOutput("extra_frame", 32'd1, 32'd0);
      end
      rise_idx = 0;
      serving  = 1'b1;
    end
    if (serving && rise_idx < 16) sdata = cur_frame[15 - rise_idx];
    else                          sdata = 1'($urandom_range(0, 1));
    if (rand_sclk) begin
      sclk_in = 1'($urandom_range(0, 1));
    end else if (half_period > 0) begin
      sclk_cnt++;
      if (sclk_cnt >= half_period) begin
        sclk_in  = ~sclk_in;
        sclk_cnt = 0;
      end
    end
  end

  // Monitor: scoreboard on sample_valid plus SCLK-edge and gap accounting around cs_n.
  always @(negedge clknexys) begin
    if (rst) begin
      if (sample_valid) begin
        valid_count++;
        if (exp_q.size() == 0) checkOutput("unexpected_valid", 32'd1, 32'd0);
        else                   checkOutput("sample", 32'(sample), 32'(exp_q.pop_front()));
      end
      if (cs_prev && !cs_n) begin
        if (check_gap && had_frame) checkOutput("gap_falls", 32'(gap_falls), 32'd3);
        so_edges = 0;
      end
      if (!cs_prev && cs_n) begin
        if (check_edges) checkOutput("sclk_edges", 32'(so_edges), 32'd16);
        had_frame = 1'b1;
        gap_falls = 0;
      end
      if (!cs_n && sclk_out && !so_prev) so_edges++;
      if (cs_n && s_prev && !sclk_in) gap_falls++;
    end
    cs_prev = cs_n;
    so_prev = sclk_out;
    s_prev  = sclk_in;
  end

  task automatic waitDone(input int tgt_valid);
    int n = 0;
    while (valid_count < tgt_valid && n < 4000) begin @(negedge clknexys); n++; end
    while (busy && n < 4000) begin @(negedge clknexys); n++; end
    if (n >= 4000) checkOutput("timeout_done", 32'd1, 32'd0);
  endtask

  task automatic applyStimulus(input int nframes, input int hp, input bit pulse_busy);
    int tgt_served = served + nframes;
    int tgt_valid  = valid_count + nframes;
    int n = 0;
    half_period = hp;
    @(posedge clknexys); #1 start = 1'b1;
    while (served < tgt_served && n < 4000) begin @(negedge clknexys); n++; end
    if (n >= 4000) checkOutput("timeout_serve", 32'd1, 32'd0);
    @(posedge clknexys); #1 start = 1'b0;
    if (pulse_busy) begin
      repeat (5) @(negedge clknexys);
      checkOutput("busy_during_pulse", 32'(busy), 32'd1);
      @(posedge clknexys); #1 start = 1'b1;
      @(posedge clknexys); #1 start = 1'b0;
    end
    waitDone(tgt_valid);
  endtask

  initial begin
    int   n;
    int   vbefore;
    bit   found;
    bit   ok;
    logic h1, h2, p;

    // Reset with random activity on every input.
    repeat (4) begin
      @(posedge clknexys); #1 start = 1'($urandom_range(0, 1));
      @(negedge clknexys);
      checkOutput("rst_cs_n", 32'(cs_n), 32'd1);
      checkOutput("rst_sclk_out", 32'(sclk_out), 32'd1);
      checkOutput("rst_sample", 32'(sample), 32'd0);
      checkOutput("rst_valid", 32'(sample_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
    end
    start     = 1'b0;
    rand_sclk = 1'b0;
    rst       = 1'b1;
    repeat (3) @(negedge clknexys);

    $display("[TB] single frame, half-period 4");
    check_edges = 1'b1;
    pushFrame(16'h0A5C, 12'hA5C);
    applyStimulus(1, 4, 1'b0);
    check_edges = 1'b0;
    checkOutput("single_valids", 32'(valid_count), 32'd1);

    $display("[TB] divide-by-2, two frames");
    pushFrame(16'h0FFF, 12'hFFF);
    pushFrame(16'h0001, 12'h001);
    applyStimulus(2, 1, 1'b0);
    checkOutput("div2_valids", 32'(valid_count), 32'd3);

    $display("[TB] continuous start, three frames");
    had_frame = 1'b0;
    check_gap = 1'b1;
    pushFrame(16'h5321, 12'h321);
    pushFrame(16'h0ABC, 12'hABC);
    pushFrame(16'hF0F0, 12'h0F0);
    applyStimulus(3, 4, 1'b1);
    repeat (60) @(negedge clknexys);
    check_gap = 1'b0;
    checkOutput("cont_valids", 32'(valid_count), 32'd6);
    checkOutput("cont_served", 32'(served), 32'd6);

    $display("[TB] start while sclk_in high");
    pushFrame(16'h0C3A, 12'hC3A);
    half_period = 4;
    n = 0;
    do begin
      p = sclk_in;
      @(negedge clknexys);
      n++;
    end while (!(sclk_in && !p) && n < 100);
    @(posedge clknexys); #1 start = 1'b1;
    @(negedge clknexys);
    h1 = sclk_in;
    h2 = 1'b0;
    @(posedge clknexys); #1 start = 1'b0;
    found = 1'b0;
    ok    = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clknexys);
      if (!cs_n) begin
        found = 1'b1;
      end else begin
        if (!sclk_out) ok = 1'b0;
        h2 = h1;
        h1 = sclk_in;
      end
    end
    checkOutput("align_found", 32'(found), 32'd1);
    checkOutput("align_fall", 32'({h2, h1}), 32'b10);
    checkOutput("align_sclk_out_high", 32'(ok), 32'd1);
    waitDone(7);
    checkOutput("align_valids", 32'(valid_count), 32'd7);

    $display("[TB] reset mid-frame");
    pushFrame(16'hBEEF, 12'hEEF);
    @(posedge clknexys); #1 start = 1'b1;
    n = 0;
    while (!(serving && rise_idx >= 7) && n < 2000) begin
      @(negedge clknexys);
      if (serving) start = 1'b0;
      n++;
    end
    start = 1'b0;
    checkOutput("abort_reached_7", 32'(rise_idx), 32'd7);
    vbefore = valid_count;
    rst = 1'b0;
    #1;
    checkOutput("abort_cs_n", 32'(cs_n), 32'd1);
    checkOutput("abort_sclk_out", 32'(sclk_out), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    repeat (3) @(negedge clknexys);
    rst = 1'b1;
    repeat (2) @(negedge clknexys);
    checkOutput("abort_no_valid", 32'(valid_count), 32'(vbefore));
    checkOutput("abort_sample_cleared", 32'(sample), 32'd0);
    pushFrame(16'h0123, 12'h123);
    applyStimulus(1, 4, 1'b0);
    checkOutput("abort_next_valids", 32'(valid_count), 32'(vbefore + 1));

    repeat (20) @(negedge clknexys);
    checkOutput("total_served", 32'(served), 32'd9);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
